// File: rtl/mips8_pkg.sv
// Shared widths and types for the 8-bit MIPS datapath.
// Register-file, write-address and forwarding blocks all import from here.
package mips8_pkg;
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NREG = 8;
    localparam int SCW  = 8;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] word_t;

    localparam reg_addr_t REG_ZERO = 3'd0;
endpackage

// File: rtl/reg_file_rd_if.sv
// Write-back, read-port and issue bundle between the pipeline and the register file.
// The pipeline drives the master side; the register file is the slave.
interface reg_file_rd_if #(
    parameter int DW  = 8,
    parameter int AW  = 3,
    parameter int SCW = 8
);
    logic            we;
    logic [AW-1:0]   wa;
    logic [DW-1:0]   wd;
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic            use1;
    logic            use2;
    logic [DW-1:0]   rd1;
    logic [DW-1:0]   rd2;
    logic            iss_v;
    logic [AW-1:0]   iss_dst;
    logic            stall;
    logic [2**AW-1:0] pend;
    logic [SCW-1:0]  stall_cnt;

    modport master (
        output we, wa, wd,
        output ra1, ra2, use1, use2,
        output iss_v, iss_dst,
        input  rd1, rd2,
        input  stall, pend, stall_cnt
    );

    modport slave (
        input  we, wa, wd,
        input  ra1, ra2, use1, use2,
        input  iss_v, iss_dst,
        output rd1, rd2,
        output stall, pend, stall_cnt
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write bitmap for multi-cycle producers and the read-hazard hits.
// A same-cycle issue overrides a write-back clear on the same register.
module reg_scoreboard #(
    parameter int AW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic             iss_v,
    input  logic [AW-1:0]    iss_dst,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic             use1,
    input  logic             use2,
    output logic [2**AW-1:0] pend,
    output logic             hit1,
    output logic             hit2
);
    import mips8_pkg::*;

    localparam int N = 2**AW;

    logic [N-1:0] pend_q;
    logic [N-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        for (int n = 1; n < N; n++) begin
            if (iss_v && iss_dst == AW'(n)) begin
                pend_d[n] = 1'b1;
            end else if (we && wa == AW'(n)) begin
                pend_d[n] = 1'b0;
            end
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

    // A write-back landing this cycle is forwarded, so it is not a hazard.
    always_comb begin
        hit1 = use1 && pend_q[ra1] && !(we && wa == ra1);
        hit2 = use2 && pend_q[ra2] && !(we && wa == ra2);
    end
endmodule

// File: rtl/reg_file_rd.sv
// 8-entry register file with write bypass, pending-write stall and stall counter.
// r0 is hardwired to zero and never stored.
module reg_file_rd #(
    parameter int DW  = mips8_pkg::DW,
    parameter int AW  = mips8_pkg::AW,
    parameter int SCW = mips8_pkg::SCW
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_rd_if.slave  bus
);
    import mips8_pkg::*;

    localparam int N = 2**AW;

    logic [DW-1:0]  regs [1:N-1];
    logic [SCW-1:0] cnt_q;
    logic           hit1;
    logic           hit2;
    logic           stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < N; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.we && bus.wa != REG_ZERO) begin
            regs[bus.wa] <= bus.wd;
        end
    end

    always_comb begin
        bus.rd1 = '0;
        if (bus.ra1 != REG_ZERO) begin
            if (bus.we && bus.wa == bus.ra1) begin
                bus.rd1 = bus.wd;
            end else begin
                bus.rd1 = regs[bus.ra1];
            end
        end
    end

    always_comb begin
        bus.rd2 = '0;
        if (bus.ra2 != REG_ZERO) begin
            if (bus.we && bus.wa == bus.ra2) begin
                bus.rd2 = bus.wd;
            end else begin
                bus.rd2 = regs[bus.ra2];
            end
        end
    end

    reg_scoreboard #(
        .AW (AW)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (bus.we),
        .wa      (bus.wa),
        .iss_v   (bus.iss_v),
        .iss_dst (bus.iss_dst),
        .ra1     (bus.ra1),
        .ra2     (bus.ra2),
        .use1    (bus.use1),
        .use2    (bus.use2),
        .pend    (bus.pend),
        .hit1    (hit1),
        .hit2    (hit2)
    );

    assign stall = hit1 | hit2;
    assign bus.stall = stall;

    // Saturates so a long load miss cannot wrap the performance counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_reg_file_rd.sv
// Directed bench for reg_file_rd: vector table plus saturation and reset sequences.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_reg_file_rd;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    reg_file_rd_if #(.DW(8), .AW(3), .SCW(8)) bus ();

    reg_file_rd #(.DW(8), .AW(3), .SCW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra1;
        logic [2:0] ra2;
        logic       use1;
        logic       use2;
        logic       iss_v;
        logic [2:0] iss_dst;
        logic [7:0] e_rd1;
        logic [7:0] e_rd2;
        logic       e_stall;
        logic [7:0] e_pend;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs [14];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] wa,
                         input logic [7:0] wd, input logic [2:0] ra1,
                         input logic [2:0] ra2, input logic use1,
                         input logic use2, input logic iss_v,
                         input logic [2:0] iss_dst);
        bus.we = we;
        bus.wa = wa;
        bus.wd = wd;
        bus.ra1 = ra1;
        bus.ra2 = ra2;
        bus.use1 = use1;
        bus.use2 = use2;
        bus.iss_v = iss_v;
        bus.iss_dst = iss_dst;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic we, input logic [2:0] wa, input logic [7:0] wd,
        input logic [2:0] ra1, input logic [2:0] ra2,
        input logic use1, input logic use2,
        input logic iss_v, input logic [2:0] iss_dst,
        input logic [7:0] e_rd1, input logic [7:0] e_rd2,
        input logic e_stall, input logic [7:0] e_pend,
        input logic [7:0] e_cnt);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.ra1 = ra1; v.ra2 = ra2;
        v.use1 = use1; v.use2 = use2;
        v.iss_v = iss_v; v.iss_dst = iss_dst;
        v.e_rd1 = e_rd1; v.e_rd2 = e_rd2;
        v.e_stall = e_stall; v.e_pend = e_pend; v.e_cnt = e_cnt;
        return v;
    endfunction

    initial begin
        //          we wa wd     ra1 ra2 u1 u2 iv dst  rd1    rd2    st pend   cnt
        vecs[0]  = mk(1, 3, 8'h5A, 3, 0, 0, 0, 0, 0, 8'h5A, 8'h00, 0, 8'h00, 0);
        vecs[1]  = mk(0, 0, 8'h00, 3, 3, 0, 0, 0, 0, 8'h5A, 8'h5A, 0, 8'h00, 0);
        vecs[2]  = mk(1, 0, 8'hFF, 0, 3, 0, 0, 0, 0, 8'h00, 8'h5A, 0, 8'h00, 0);
        vecs[3]  = mk(0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
        vecs[4]  = mk(0, 0, 8'h00, 0, 0, 1, 1, 1, 4, 8'h00, 8'h00, 0, 8'h00, 0);
        vecs[5]  = mk(0, 0, 8'h00, 0, 4, 0, 1, 0, 0, 8'h00, 8'h00, 1, 8'h10, 0);
        vecs[6]  = mk(0, 0, 8'h00, 0, 4, 0, 1, 0, 0, 8'h00, 8'h00, 1, 8'h10, 1);
        vecs[7]  = mk(1, 4, 8'h11, 0, 4, 0, 1, 0, 0, 8'h00, 8'h11, 0, 8'h10, 2);
        vecs[8]  = mk(0, 0, 8'h00, 0, 4, 0, 1, 0, 0, 8'h00, 8'h11, 0, 8'h00, 2);
        vecs[9]  = mk(1, 5, 8'h77, 5, 0, 0, 0, 1, 5, 8'h77, 8'h00, 0, 8'h00, 2);
        vecs[10] = mk(0, 0, 8'h00, 5, 0, 0, 0, 0, 0, 8'h77, 8'h00, 0, 8'h20, 2);
        vecs[11] = mk(0, 0, 8'h00, 5, 0, 1, 0, 0, 0, 8'h77, 8'h00, 1, 8'h20, 2);
        vecs[12] = mk(1, 5, 8'h78, 5, 0, 1, 0, 1, 4, 8'h78, 8'h00, 0, 8'h20, 3);
        vecs[13] = mk(0, 0, 8'h00, 4, 5, 1, 1, 0, 0, 8'h11, 8'h78, 1, 8'h10, 3);

        rst_n = 1'b0;
        drive(0, 0, 0, 3, 7, 1, 1, 0, 0);
        step();
        step();
        @(negedge clk);
        check("rst_pend", 32'(bus.pend), 32'h00);
        check("rst_stall", 32'(bus.stall), 32'h0);
        check("rst_cnt", 32'(bus.stall_cnt), 32'h00);
        check("rst_rd1", 32'(bus.rd1), 32'h00);
        check("rst_rd2", 32'(bus.rd2), 32'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1,
                  vecs[i].ra2, vecs[i].use1, vecs[i].use2,
                  vecs[i].iss_v, vecs[i].iss_dst);
            @(negedge clk);
            check($sformatf("v%0d_rd1", i), 32'(bus.rd1), 32'(vecs[i].e_rd1));
            check($sformatf("v%0d_rd2", i), 32'(bus.rd2), 32'(vecs[i].e_rd2));
            check($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
            check($sformatf("v%0d_pend", i), 32'(bus.pend), 32'(vecs[i].e_pend));
            check($sformatf("v%0d_cnt", i), 32'(bus.stall_cnt), 32'(vecs[i].e_cnt));
            @(posedge clk);
            #1;
        end

        // Hazard on r4 held long enough to saturate the counter (starts at 4).
        drive(0, 0, 0, 4, 0, 1, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            if (i == 100) begin
                @(negedge clk);
                check("sat_mid_cnt", 32'(bus.stall_cnt), 32'd104);
            end
            step();
        end
        @(negedge clk);
        check("sat_cnt", 32'(bus.stall_cnt), 32'hFF);
        check("sat_stall", 32'(bus.stall), 32'h1);
        check("sat_pend", 32'(bus.pend), 32'h10);
        check("sat_rd1", 32'(bus.rd1), 32'h11);
        step();
        @(negedge clk);
        check("sat_hold_cnt", 32'(bus.stall_cnt), 32'hFF);

        // Reset mid-hazard beats a simultaneous write and issue.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(1, 6, 8'hAA, 4, 6, 1, 1, 1, 6);
        @(negedge clk);
        check("inrst_stall", 32'(bus.stall), 32'h1);
        check("inrst_rd2_byp", 32'(bus.rd2), 32'hAA);
        step();
        rst_n = 1'b1;
        drive(0, 0, 0, 4, 6, 1, 1, 0, 0);
        @(negedge clk);
        check("postrst_pend", 32'(bus.pend), 32'h00);
        check("postrst_stall", 32'(bus.stall), 32'h0);
        check("postrst_rd1", 32'(bus.rd1), 32'h00);
        check("postrst_rd2", 32'(bus.rd2), 32'h00);
        check("postrst_cnt", 32'(bus.stall_cnt), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
